// File: rtl/rlg_sched.sv
// Round-robin scheduler sharing one rlg_in reversible layer between two requesters.
// Each pass of rlg_in takes one clock; the result is held until the consumer takes it.
module rlg_sched #(
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [127:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [127:0]  req1_data,
  output logic          req1_ready,
  input  logic [RW-1:0] rounds,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          out_src,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q;
  logic          prio_q, src_q, out_valid_q, out_src_q, busy_q;
  logic [RW-1:0] cnt_q;
  logic [127:0]  data_q, out_data_q;
  logic          gnt1, acc0, acc1;
  logic [127:0]  in_data, pass_data;

  // Word view: w7=[127:112] ... w0=[15:0].
  // Fredkin (w6 controls swap of w5/w4), Feynman (w7 ^= w3), then scl: rotate left 64.
  function automatic logic [127:0] rlg_in(input logic [127:0] x);
    logic [127:0] y;
    y            = x;
    y[95:80]     = (x[95:80] & ~x[111:96]) | (x[79:64] & x[111:96]);
    y[79:64]     = (x[79:64] & ~x[111:96]) | (x[95:80] & x[111:96]);
    y[127:112]   = x[127:112] ^ x[63:48];
    return {y[63:0], y[127:64]};
  endfunction

  // Ties go to prio_q; a lone valid always wins.
  assign gnt1       = req1_valid && (!req0_valid || prio_q);
  assign acc1       = rst_n && (state_q == IDLE) && gnt1;
  assign acc0       = rst_n && (state_q == IDLE) && req0_valid && !gnt1;
  assign req0_ready = acc0;
  assign req1_ready = acc1;
  assign in_data    = acc1 ? req1_data : req0_data;
  assign pass_data  = rlg_in(data_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      src_q       <= 1'b0;
      cnt_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc0 || acc1) begin
            data_q <= in_data;
            cnt_q  <= rounds;
            src_q  <= acc1;
            busy_q <= 1'b1;
            if (rounds == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= in_data;
              out_src_q   <= acc1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          data_q <= pass_data;
          cnt_q  <= cnt_q - RW'(1);
          if (cnt_q == RW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= pass_data;
            out_src_q   <= src_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            busy_q      <= 1'b0;
            prio_q      <= ~src_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rlg_sched.sv
// Bench for rlg_sched: transaction-level model checked every cycle, plus directed
// vectors with hand-computed results and latencies.
module tb_rlg_sched;

  logic         clk, rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [127:0] req0_data, req1_data, out_data;
  logic [3:0]   rounds;
  logic         out_valid, out_ready, out_src, busy;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  localparam logic [127:0] ONES  = {128{1'b1}};
  localparam logic [127:0] PASS1 = 128'hFFFFFFFFFFFFFFFF0000FFFFFFFFFFFF;
  localparam logic [127:0] PASS2 = 128'h0000FFFFFFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [127:0] PAT   = 128'h0123456789ABCDEF0011223344556677;

  rlg_sched #(.RW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rounds(rounds),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference layer on an array of 16-bit words.
  function automatic logic [127:0] m_rlg(input logic [127:0] x);
    logic [15:0]  w [8];
    logic [15:0]  v [8];
    logic [127:0] y;
    for (int i = 0; i < 8; i++) w[i] = x[16*i +: 16];
    v = w;
    for (int b = 0; b < 16; b++)
      if (w[6][b]) begin
        v[5][b] = w[4][b];
        v[4][b] = w[5][b];
      end
    v[7] = w[7] ^ w[3];
    y = '0;
    for (int i = 0; i < 8; i++) y[16*((i+4)%8) +: 16] = v[i];
    return y;
  endfunction

  function automatic logic [127:0] m_apply(input logic [127:0] x, input int n);
    logic [127:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = m_rlg(r);
    return r;
  endfunction

  // Transaction model: the final result is computed up front at accept,
  // then revealed after the required number of cycles.
  logic         m_busy, m_outv, m_src, m_prio;
  int           m_cnt;
  logic [127:0] m_res;
  logic         exp_r0, exp_r1;

  assign exp_r1 = rst_n && !m_busy && req1_valid && (!req0_valid || m_prio);
  assign exp_r0 = rst_n && !m_busy && req0_valid && !exp_r1;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 0; m_outv <= 0; m_src <= 0; m_prio <= 0; m_cnt <= 0; m_res <= '0;
    end else if (!m_busy) begin
      if (exp_r0 || exp_r1) begin
        m_busy <= 1;
        m_src  <= exp_r1;
        m_res  <= m_apply(exp_r1 ? req1_data : req0_data, int'(rounds));
        if (rounds == 0) m_outv <= 1;
        else m_cnt <= int'(rounds);
      end
    end else if (!m_outv) begin
      if (m_cnt == 1) m_outv <= 1;
      m_cnt <= m_cnt - 1;
    end else if (out_ready) begin
      m_busy <= 0;
      m_outv <= 0;
      m_prio <= !m_src;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon out_valid", out_valid, m_outv);
      check("mon busy", busy, m_busy);
      check("mon out_data", out_data, m_outv ? m_res : '0);
      check("mon out_src", out_src, m_outv ? m_src : 1'b0);
      check("mon req0_ready", req0_ready, exp_r0);
      check("mon req1_ready", req1_ready, exp_r1);
      check("mon ready exclusive", req0_ready && req1_ready, 0);
    end
  end

  // Single block with out_ready=1; checks result, source and latency literally.
  task automatic send(input bit k, input logic [127:0] d, input logic [3:0] r,
                      input logic [127:0] exp, input string nm);
    int n;
    bit got;
    @(posedge clk); #1;
    rounds = r;
    if (k) begin req1_valid = 1; req1_data = d; end
    else   begin req0_valid = 1; req0_data = d; end
    got = 0;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk);
      got = k ? req1_ready : req0_ready;
    end
    check({nm, " accept"}, got, 1);
    if (!got) begin req0_valid = 0; req1_valid = 0; return; end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    rounds = ~r;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 40);
    check({nm, " latency"}, n, int'(r) + 1);
    check({nm, " data"}, out_data, exp);
    check({nm, " src"}, out_src, k);
    check({nm, " busy in done"}, busy, 1);
    @(negedge clk);
    check({nm, " valid one cycle"}, out_valid, 0);
    check({nm, " idle after"}, busy, 0);
  endtask

  initial begin
    logic         srcs [4];
    int           got_n, n;
    logic [127:0] hold_d;
    logic         hold_s;

    rst_n = 0; out_ready = 1; rounds = 0;
    req0_valid = 1; req0_data = ONES; req1_valid = 0; req1_data = '0;
    @(posedge clk); #1;
    mon_en = 1;
    @(negedge clk);
    check("reset req0_ready", req0_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, '0);
    check("reset busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1; req0_valid = 0;

    // pin the reference layer itself
    check("model pass1", m_rlg(ONES), PASS1);
    check("model pass2", m_apply(ONES, 2), PASS2);

    send(0, ONES, 4'd1, PASS1, "r1 ones");
    send(0, ONES, 4'd2, PASS2, "r2 ones");
    send(0, '0, 4'd15, '0, "r15 zero");
    send(0, PAT, 4'd0, PAT, "r0 bypass");

    // reset in the middle of a 10-pass block
    @(posedge clk); #1;
    rounds = 4'd10; req0_valid = 1; req0_data = PAT;
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("midrun reset out_valid", out_valid, 0);
    check("midrun reset busy", busy, 0);
    repeat (12) @(negedge clk);
    check("midrun no late output", out_valid, 0);
    send(1, ONES, 4'd2, PASS2, "req1 after reset");

    // both requesters held high: grants alternate
    @(posedge clk); #1;
    rounds = 4'd1;
    req0_valid = 1; req0_data = PAT;
    req1_valid = 1; req1_data = ONES;
    got_n = 0;
    for (int t = 0; t < 80 && got_n < 4; t++) begin
      @(negedge clk);
      if (out_valid) begin srcs[got_n] = out_src; got_n++; end
    end
    req0_valid = 0; req1_valid = 0;
    check("alt count", got_n, 4);
    for (int i = 0; i < got_n; i++) check($sformatf("alt src %0d", i), srcs[i], i % 2);

    // consumer stalls for 5 cycles in DONE
    @(posedge clk); #1;
    out_ready = 0; rounds = 4'd1; req0_valid = 1; req0_data = ONES;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 1; req1_data = PAT;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 40);
    check("stall valid seen", out_valid, 1);
    check("stall data", out_data, PASS1);
    hold_d = out_data; hold_s = out_src;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall valid hold", out_valid, 1);
      check("stall data hold", out_data, hold_d);
      check("stall src hold", out_src, hold_s);
      check("stall no ready", req0_ready || req1_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1; req1_valid = 0;
    @(negedge clk);
    check("stall release valid", out_valid, 1);
    @(negedge clk);
    check("stall then idle", busy, 0);
    check("stall then no valid", out_valid, 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
